// File: rtl/breathing_light_multi.sv
// Multi-channel breathing light: one shared PWM counter and breathing phase
// drive CHANNELS LEDs with a fixed phase offset between adjacent channels.
//
// Ports:
//   clk   - system clock
//   rst   - synchronous reset, active-high
//   mode  - 00 off, 01 on, 10 breathe, 11 blink (taken at frame boundary)
//   en    - per-channel enable, applied on the next led update
//   led   - registered LED drive, bit i = channel i
//   check - one-cycle pulse at the end of each full breathing cycle
module breathing_light_multi #(
    parameter int CHANNELS        = 4,
    parameter int PWM_BITS        = 8,
    parameter int FRAMES_PER_STEP = 64,
    parameter int PHASE_STEP      = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] en,
    output logic [CHANNELS-1:0] led,
    output logic                check
);

    localparam int PW = PWM_BITS + 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
    localparam logic [PW-1:0]       PHASE_MAX  = '1;
    localparam logic [FW-1:0]       FRAME_LAST = FW'(FRAMES_PER_STEP - 1);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
    logic [FW-1:0]                      frame_cnt_q, frame_cnt_d;
    logic [PW-1:0]                      phase_q, phase_d;
    logic [1:0]                         mode_q, mode_d;
    logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [CHANNELS-1:0]                led_q, led_d;
    logic                               check_q, check_d;

    logic fb;
    logic step;
    logic restart;

    // Offset of channel i from the shared phase; wraps naturally to PW bits.
    function automatic logic [PW-1:0] chan_off(input int i);
        return PW'(i * PHASE_STEP);
    endfunction

    // Triangle fold: rising half passes through, falling half is inverted.
    function automatic logic [PWM_BITS-1:0] tri_wave(input logic [PW-1:0] p);
        return p[PWM_BITS] ? ~p[PWM_BITS-1:0] : p[PWM_BITS-1:0];
    endfunction

    always_comb begin
        fb      = (pwm_cnt_q == PWM_MAX);
        step    = (frame_cnt_q == FRAME_LAST);
        restart = fb && (mode == MODE_BREATHE) && (mode_q != MODE_BREATHE);

        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        duty_d      = duty_q;
        check_d     = 1'b0;

        if (fb) begin
            mode_d = mode;
            if (restart) begin
                // Entering breathe always starts from the dark end.
                frame_cnt_d = '0;
                phase_d     = '0;
            end else begin
                frame_cnt_d = step ? '0 : frame_cnt_q + 1'b1;
                if (step) begin
                    phase_d = phase_q + 1'b1;
                end
                check_d = step && (phase_q == PHASE_MAX) &&
                          (mode_q == MODE_BREATHE);
            end
            // Duty is only reloaded here so a frame is never cut mid-way.
            for (int i = 0; i < CHANNELS; i++) begin
                duty_d[i] = tri_wave(phase_d + chan_off(i));
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            logic [PW-1:0] cph;
            cph = phase_q + chan_off(i);
            unique case (mode_q)
                MODE_OFF:     led_d[i] = 1'b0;
                MODE_ON:      led_d[i] = 1'b1;
                MODE_BREATHE: led_d[i] = (pwm_cnt_q < duty_q[i]);
                MODE_BLINK:   led_d[i] = cph[PWM_BITS];
                default:      led_d[i] = 1'b0;
            endcase
            led_d[i] = led_d[i] & en[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q   <= '0;
            frame_cnt_q <= '0;
            phase_q     <= '0;
            mode_q      <= MODE_OFF;
            duty_q      <= '0;
            led_q       <= '0;
            check_q     <= 1'b0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            duty_q      <= duty_d;
            led_q       <= led_d;
            check_q     <= check_d;
        end
    end

    assign led   = led_q;
    assign check = check_q;

endmodule

// File: tb/tb_breathing_light_multi.sv
// Randomised bench for breathing_light_multi in the small configuration
// (N=3, 2 frames per step, 2 channels, offset 4) against a frame-level model.
module tb_breathing_light_multi;

    localparam int N     = 3;
    localparam int FPS   = 2;
    localparam int CH    = 2;
    localparam int PS    = 4;
    localparam int FRAME = 1 << N;
    localparam int P     = 2 * FRAME;
    localparam int CYC   = FPS * P;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = 2'b10;
    logic [CH-1:0] en = '1;
    logic [CH-1:0] led;
    logic          check;

    breathing_light_multi #(
        .CHANNELS       (CH),
        .PWM_BITS       (N),
        .FRAMES_PER_STEP(FPS),
        .PHASE_STEP     (PS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .en   (en),
        .led  (led),
        .check(check)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: pwm position, frames since origin, latched mode, duties.
    int            m_p;
    int            m_k;
    int            m_mq;
    int            m_duty [CH];
    logic [CH-1:0] m_led;
    logic          m_chk;

    int ncyc = 0;
    int last_chk = -1;
    int npulse = 0;
    bit track = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, ncyc, got, exp);
        end
    endtask

    function automatic int tri_m(input int p);
        int q;
        q = p % P;
        return (q < FRAME) ? q : (P - 1 - q);
    endfunction

    function automatic int phase_m();
        return (m_k / FPS) % P;
    endfunction

    task automatic model_reset();
        m_p = 0;
        m_k = 0;
        m_mq = 0;
        for (int i = 0; i < CH; i++) m_duty[i] = 0;
        m_led = '0;
        m_chk = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [1:0] md,
                              input logic [CH-1:0] e);
        logic [CH-1:0] ln;
        logic          cn;
        int            ph;
        if (r) begin
            model_reset();
            return;
        end
        ln = '0;
        cn = 1'b0;
        for (int i = 0; i < CH; i++) begin
            ph = (phase_m() + i * PS) % P;
            if (!e[i] || m_mq == 0) ln[i] = 1'b0;
            else if (m_mq == 1)     ln[i] = 1'b1;
            else if (m_mq == 2)     ln[i] = (m_p < m_duty[i]);
            else                    ln[i] = (ph >= FRAME);
        end
        if (m_p == FRAME - 1) begin
            if (md == 2 && m_mq != 2) begin
                m_k = 0;
            end else begin
                m_k++;
                if (m_mq == 2 && (m_k % CYC) == 0) cn = 1'b1;
            end
            m_mq = md;
            for (int i = 0; i < CH; i++)
                m_duty[i] = tri_m(phase_m() + i * PS);
        end
        m_p = (m_p + 1) % FRAME;
        m_led = ln;
        m_chk = cn;
    endtask

    task automatic tick(input logic r, input logic [1:0] md,
                        input logic [CH-1:0] e);
        @(negedge clk);
        check_eq("led", 32'(led), 32'(m_led));
        check_eq("check", 32'(check), 32'(m_chk));
        if (track && check === 1'b1) begin
            npulse++;
            if (last_chk >= 0) check_eq("period", ncyc - last_chk, CYC * FRAME);
            last_chk = ncyc;
        end
        rst  = r;
        mode = md;
        en   = e;
        model_step(r, md, e);
        ncyc++;
    endtask

    task automatic run(input int n, input logic [1:0] md,
                       input logic [CH-1:0] e);
        for (int i = 0; i < n; i++) tick(1'b0, md, e);
    endtask

    initial begin
        logic [1:0]    md;
        logic [CH-1:0] e;
        model_reset();

        // Reset, then continuous breathing over three full periods.
        tick(1'b1, 2'b10, 2'b11);
        track = 1'b1;
        run(800, 2'b10, 2'b11);
        track = 1'b0;
        check_eq("npulse", npulse, 3);

        // On / off switched mid-frame.
        run($urandom_range(1, 7), 2'b10, 2'b11);
        run(40 + $urandom_range(0, 7), 2'b01, 2'b11);
        run(40 + $urandom_range(0, 7), 2'b00, 2'b11);

        // Blink, then back to breathe at an arbitrary time.
        run(300 + $urandom_range(0, 50), 2'b11, 2'b11);
        run(300, 2'b10, 2'b11);

        // Short reset mid-frame, then enable masking.
        run($urandom_range(1, 6), 2'b10, 2'b11);
        tick(1'b1, 2'b10, 2'b11);
        run(100, 2'b10, 2'b11);
        for (int i = 0; i < 60; i++) begin
            e = (i % 2 == 0) ? 2'b01 : 2'b10;
            run($urandom_range(1, 5), 2'b11, e);
        end

        // Random traffic.
        md = 2'b10;
        e = 2'b11;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) e = CH'($urandom);
            tick(($urandom_range(0, 399) == 0), md, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
